// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Divisors below DIV_MIN are rejected at load time.
package clk_div_pkg;

    localparam int CNT_W_DEF = 26;
    localparam int DIV_MIN   = 2;

    // High-phase length in whole source cycles for divisor n.
    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_halfcyc.sv
// Negedge half-cycle stretcher and output OR for odd divisors.
// This is the only falling-edge logic in the divider.
module clk_div_halfcyc
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic q_p,
    input  logic odd,
    output logic clk_out
);

    logic q_n;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) q_n <= 1'b0;
        else       q_n <= q_p;
    end

    // Odd ratios borrow half a source period from q_n to reach 50% duty.
    assign clk_out = odd ? (q_p | q_n) : q_p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with glitch-free divisor
// reload at period boundaries, run enable and a clk-domain rise tick.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_err,
    output logic             div_pending,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick_rise
);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] div_r, div_next;
    logic [CNT_W-1:0] pend, pend_next;
    logic             pend_v, pend_v_next;
    logic             run;
    logic             q_p, q_p_next;
    logic             tick_r, tick_next;
    logic             err_r, err_next;
    logic             load_ok, upd_v, at_wrap, boundary;
    logic [CNT_W-1:0] upd_val, half_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_ok     = div_load && (div_in >= CNT_W'(DIV_MIN));
        err_next    = div_load && !load_ok;
        upd_v       = pend_v || load_ok;
        upd_val     = load_ok ? div_in : pend;
        at_wrap     = (cnt == div_r - CNT_W'(1));
        // Idle (en low) or the first start cycle is a safe point to swap N.
        boundary    = !en || !run || at_wrap;

        div_next    = div_r;
        pend_next   = upd_val;
        pend_v_next = upd_v;
        if (boundary && upd_v) begin
            div_next    = upd_val;
            pend_v_next = 1'b0;
        end

        if (boundary) cnt_next = '0;
        else          cnt_next = cnt + CNT_W'(1);

        // Phase and tick are computed for the upcoming cycle so both are flops.
        half_next = CNT_W'(half(32'(div_next)));
        q_p_next  = en && (cnt_next < half_next);
        tick_next = en && (cnt_next == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            div_r  <= CNT_W'(DIV_DEFAULT);
            pend   <= '0;
            pend_v <= 1'b0;
            run    <= 1'b0;
            q_p    <= 1'b0;
            tick_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            div_r  <= div_next;
            pend   <= pend_next;
            pend_v <= pend_v_next;
            run    <= en;
            q_p    <= q_p_next;
            tick_r <= tick_next;
            err_r  <= err_next;
        end
    end

    clk_div_halfcyc u_halfcyc (
        .clk     (clk),
        .reset   (reset),
        .q_p     (q_p),
        .odd     (div_r[0]),
        .clk_out (clk_out)
    );

    assign div_cur     = div_r;
    assign div_pending = pend_v;
    assign div_err     = err_r;
    assign tick_rise   = tick_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; clock period is 10 time units.
// clk_out edges are timestamped so periods and high times are exact.
module tb_clk_div_prog;

    logic        clk;
    logic        reset;
    logic        en;
    logic [25:0] div_in;
    logic        div_load;
    logic        div_err;
    logic        div_pending;
    logic [25:0] div_cur;
    logic        clk_out;
    logic        tick_rise;

    int n_checks = 0;
    int n_fail   = 0;

    longint rise_q[$];
    longint high_q[$];
    longint last_rise = 0;

    clk_div_prog #(.CNT_W(26), .DIV_DEFAULT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .div_in      (div_in),
        .div_load    (div_load),
        .div_err     (div_err),
        .div_pending (div_pending),
        .div_cur     (div_cur),
        .clk_out     (clk_out),
        .tick_rise   (tick_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk_out) begin
        rise_q.push_back(longint'($time) - last_rise);
        last_rise = longint'($time);
    end

    always @(negedge clk_out) high_q.push_back(longint'($time) - last_rise);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        rise_q.delete();
        high_q.delete();
    endtask

    // Advance to the cycle where tick_rise is high (cnt == 0), bounded.
    task automatic sync_tick;
        int n = 0;
        step();
        while (tick_rise !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (tick_rise !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_tick: tick_rise never seen within %0d cycles", n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0;
        #23;
        n_checks++; if (div_cur !== 26'd3) begin n_fail++; $display("FAIL reset_div_cur: got %0d want 3", div_cur); end
        n_checks++; if (div_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", div_pending); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        n_checks++; if (tick_rise !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick_rise); end
        n_checks++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", div_err); end
        step();
        reset = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_default;
        int ticks = 0;
        step();
        n_checks++; if (clk_out !== 1'b1 || tick_rise !== 1'b1) begin n_fail++; $display("FAIL default_start: clk_out=%b tick=%b want 1 1", clk_out, tick_rise); end
        clear_q();
        for (int i = 0; i < 9; i++) begin
            step();
            if (tick_rise === 1'b1) ticks++;
        end
        n_checks++; if (ticks != 3) begin n_fail++; $display("FAIL default_ticks: got %0d want 3", ticks); end
        n_checks++; if (rise_q.size() != 3 || rise_q[0] != 30 || rise_q[2] != 30) begin n_fail++; $display("FAIL default_period: size %0d first %0d want 3 x 30", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1); end
        n_checks++; if (high_q.size() < 2 || high_q[0] != 15 || high_q[1] != 15) begin n_fail++; $display("FAIL default_high: size %0d first %0d want 15", high_q.size(), (high_q.size() > 0) ? high_q[0] : -1); end
    endtask

    task automatic test_load_4;
        sync_tick();
        div_in = 26'd4; div_load = 1'b1;
        step();
        div_load = 1'b0;
        n_checks++; if (div_pending !== 1'b1 || div_cur !== 26'd3) begin n_fail++; $display("FAIL load4_pending: pend=%b cur=%0d want 1 3", div_pending, div_cur); end
        step();
        n_checks++; if (div_pending !== 1'b1) begin n_fail++; $display("FAIL load4_still_pending: got %b want 1", div_pending); end
        step();
        n_checks++; if (div_pending !== 1'b0 || div_cur !== 26'd4) begin n_fail++; $display("FAIL load4_applied: pend=%b cur=%0d want 0 4", div_pending, div_cur); end
        n_checks++; if (rise_q.size() == 0 || rise_q[rise_q.size()-1] != 30) begin n_fail++; $display("FAIL load4_last_old_period: got %0d want 30", (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : -1); end
        clear_q();
        for (int i = 0; i < 9; i++) step();
        n_checks++; if (rise_q.size() != 2 || rise_q[0] != 40 || rise_q[1] != 40) begin n_fail++; $display("FAIL load4_period: size %0d first %0d want 2 x 40", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1); end
        n_checks++; if (high_q.size() != 2 || high_q[0] != 20 || high_q[1] != 20) begin n_fail++; $display("FAIL load4_high: size %0d first %0d want 2 x 20", high_q.size(), (high_q.size() > 0) ? high_q[0] : -1); end
    endtask

    task automatic test_last_wins;
        sync_tick();
        div_in = 26'd5; div_load = 1'b1;
        step();
        div_in = 26'd7;
        step();
        div_load = 1'b0;
        n_checks++; if (div_pending !== 1'b1 || div_cur !== 26'd4) begin n_fail++; $display("FAIL last_wins_pending: pend=%b cur=%0d want 1 4", div_pending, div_cur); end
        step();
        step();
        n_checks++; if (div_pending !== 1'b0 || div_cur !== 26'd7) begin n_fail++; $display("FAIL last_wins_applied: pend=%b cur=%0d want 0 7", div_pending, div_cur); end
        clear_q();
        for (int i = 0; i < 15; i++) step();
        n_checks++; if (rise_q.size() != 2 || rise_q[0] != 70 || rise_q[1] != 70) begin n_fail++; $display("FAIL last_wins_period: size %0d first %0d want 2 x 70", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1); end
        n_checks++; if (high_q.size() != 2 || high_q[0] != 35 || high_q[1] != 35) begin n_fail++; $display("FAIL last_wins_high: size %0d first %0d want 2 x 35", high_q.size(), (high_q.size() > 0) ? high_q[0] : -1); end
    endtask

    task automatic test_div_err;
        sync_tick();
        clear_q();
        div_in = 26'd1; div_load = 1'b1;
        step();
        div_in = 26'd6;
        n_checks++; if (div_err !== 1'b1 || div_pending !== 1'b0 || div_cur !== 26'd7) begin n_fail++; $display("FAIL err1: err=%b pend=%b cur=%0d want 1 0 7", div_err, div_pending, div_cur); end
        step();
        div_in = 26'd0;
        n_checks++; if (div_err !== 1'b0 || div_pending !== 1'b1) begin n_fail++; $display("FAIL err_valid_load: err=%b pend=%b want 0 1", div_err, div_pending); end
        step();
        div_load = 1'b0;
        n_checks++; if (div_err !== 1'b1 || div_pending !== 1'b1 || div_cur !== 26'd7) begin n_fail++; $display("FAIL err0_keeps_pending: err=%b pend=%b cur=%0d want 1 1 7", div_err, div_pending, div_cur); end
        step();
        n_checks++; if (div_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", div_err); end
        sync_tick();
        n_checks++; if (div_cur !== 26'd6 || div_pending !== 1'b0) begin n_fail++; $display("FAIL err_pending_applied: cur=%0d pend=%b want 6 0", div_cur, div_pending); end
        n_checks++; if (rise_q.size() != 1 || rise_q[0] != 70 || high_q.size() != 1 || high_q[0] != 35) begin n_fail++; $display("FAIL err_output_undisturbed: rises %0d highs %0d want 70/35", rise_q.size(), high_q.size()); end
    endtask

    task automatic test_enable;
        sync_tick();
        step();
        en = 1'b0;
        step();
        n_checks++; if (clk_out !== 1'b0 || tick_rise !== 1'b0) begin n_fail++; $display("FAIL en_drop: clk_out=%b tick=%b want 0 0", clk_out, tick_rise); end
        step(); step(); step();
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL en_idle: clk_out=%b want 0", clk_out); end
        clear_q();
        en = 1'b1;
        step();
        n_checks++; if (clk_out !== 1'b1 || tick_rise !== 1'b1) begin n_fail++; $display("FAIL en_restart: clk_out=%b tick=%b want 1 1", clk_out, tick_rise); end
        for (int i = 0; i < 7; i++) step();
        n_checks++; if (rise_q.size() != 2 || rise_q[1] != 60) begin n_fail++; $display("FAIL en_first_period: size %0d got %0d want 60", rise_q.size(), (rise_q.size() > 1) ? rise_q[1] : -1); end
        n_checks++; if (high_q.size() < 1 || high_q[0] != 30) begin n_fail++; $display("FAIL en_first_high: got %0d want 30", (high_q.size() > 0) ? high_q[0] : -1); end
    endtask

    task automatic test_async_reset;
        en = 1'b0; div_in = 26'd3; div_load = 1'b1;
        step();
        div_load = 1'b0;
        n_checks++; if (div_cur !== 26'd3 || div_pending !== 1'b0) begin n_fail++; $display("FAIL idle_load_immediate: cur=%0d pend=%b want 3 0", div_cur, div_pending); end
        en = 1'b1;
        step();
        @(posedge clk);
        #2;
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL stretch_high: clk_out=%b want 1", clk_out); end
        reset = 1'b1;
        #1;
        n_checks++; if (clk_out !== 1'b0 || tick_rise !== 1'b0 || div_pending !== 1'b0) begin n_fail++; $display("FAIL async_reset: clk_out=%b tick=%b pend=%b want 0 0 0", clk_out, tick_rise, div_pending); end
        step(); step();
        reset = 1'b0;
        step();
        n_checks++; if (div_cur !== 26'd3) begin n_fail++; $display("FAIL reset_release_div: got %0d want 3", div_cur); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_load_4();
        test_last_wins();
        test_div_err();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider with 50% duty for both even and odd ratios.
- Generalises the fixed divide-by-2/3/10 blocks into one parametrised unit with a safe divisor reload, an enable, and a clk-domain rise tick.
- Feeds LED/blink and slow-strobe logic downstream of the free-running prescaler.
- The tick output is the preferred enable for downstream logic; clk_out is for pins/LEDs only.

Parameters:
- CNT_W, 26, width of divisor and internal counter.
- DIV_DEFAULT, 3, divisor after reset. Legal range is 2 to 2^CNT_W-1.

Ports:
- clk  input  1  source clock
- reset  input  1  reset, asynchronous, active-high
- en  input  1  divider run enable
- div_in  input  CNT_W  new divisor value N
- div_load  input  1  one-cycle strobe; sample div_in
- div_err  output  1  one-cycle pulse; div_in < 2 was rejected
- div_pending  output  1  a loaded divisor is waiting for the period boundary
- div_cur  output  CNT_W  divisor currently in effect
- clk_out  output  1  divided clock, 50% duty
- tick_rise  output  1  one-clk pulse aligned with each clk_out rising edge

Behaviour:
- Reset (async): cnt=0, div_cur=DIV_DEFAULT, pend=0, div_pending=0, q_p=0, q_n=0, clk_out=0, tick_rise=0, div_err=0.
- Counter:
  - When en=1, cnt counts 0..N-1 on posedge clk, then wraps to 0.
  - N = div_cur. H = N>>1 (CNT_W-bit compare).
- Phase register q_p (posedge): in the clk cycle where cnt==k, q_p = (k < H) for even N, or (k <= H-1) for odd N.
- Half-cycle stretcher q_n (negedge clk, async reset): q_n <= q_p.
- clk_out:
  - Even N: clk_out = q_p.
  - Odd N: clk_out = q_p | q_n.
  - Result: high for exactly N/2 source periods, period exactly N.
  - Examples: N=3 gives 1.5 high / 1.5 low; N=2 gives 1/1.
- tick_rise: registered; high for exactly the one clk cycle where cnt==0 and en=1.
- Divisor load:
  - div_load with div_in>=2 stores the value into pend and sets div_pending=1.
  - Pending value is applied at the next wrap (cycle where cnt==N-1 advances to 0). div_cur updates and div_pending clears on that edge. No runt or stretched period is ever produced.
  - Load in the same cycle as the wrap: the new value is applied at that wrap.
  - A second load while pending overwrites pend; last value wins.
  - div_in < 2: no state change; div_err=1 for one cycle; an existing pending value is kept.
- Enable:
  - en=0: cnt forced to 0 and q_p=0 next posedge; q_n follows at the next negedge, so clk_out is low within 1 source period.
  - While en=0, a pending divisor applies immediately on the next posedge.
  - en 0->1: the first cycle has cnt=0, clk_out rises and tick_rise=1 in that cycle (1-cycle latency from en).
- Reset mid-operation: all state drops immediately and asynchronously, including the negedge flop.
- No combinational path from inputs to clk_out, except the OR of the two flops.

Decomposition:
- Package clk_div_pkg:
  - constant DIV_MIN=2
  - default CNT_W=26
  - function half(N) returning N>>1
- Sub-module clk_div_halfcyc:
  - Contains the negedge q_n flop plus the odd/even output OR.
  - Isolated because it is the only negedge logic in the block, and needs its own timing constraint and review.

Test Plan:
- Reset default, clk period 10 ns, en=1: clk_out high 15 ns / low 15 ns, period 30 ns; tick_rise every 3rd cycle.
- Load div_in=4 mid-period with N=3:
  - div_pending=1 until the wrap.
  - Current period completes at 30 ns, then periods of 40 ns at 20/20.
  - div_cur=4 after the wrap.
- Load 5, then 7 before the boundary: only 7 takes effect; periods of 70 ns at 35/35; no intermediate 50 ns period.
- div_in=1 or 0: div_err pulses 1 cycle; div_cur and div_pending unchanged; output undisturbed.
- Drop en mid-high phase at N=6: clk_out low within 10 ns. Re-assert: clk_out rises and tick_rise=1 on the first posedge; first period is 60 ns.
- Assert reset asynchronously mid-negedge phase at N=3: clk_out=0 with no clock edge; div_cur=3 after release.
